// File: rtl/conv_pkg.sv
// conv_pkg: shared types and defaults for the convolution scheduler
package conv_pkg;
  localparam int F_DEF = 3;
  localparam int CONV_LAT_DEF = 7;
  localparam int TAG_DIM = 7;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  typedef struct packed {
    logic live;
    logic win;
    logic [TAG_DIM-1:0] row;
    logic [TAG_DIM-1:0] col;
  } tag_t;
endpackage

// File: rtl/conv_tag_delay.sv
// conv_tag_delay: fixed-depth shift line carrying read tags alongside the conv pipeline
module conv_tag_delay import conv_pkg::*; #(
  parameter int DEPTH = 1 + CONV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tagIn,
  output tag_t tagOut,
  output logic empty
);
  tag_t stage [DEPTH];
  // shift one slot per cycle; reset flushes every in-flight tag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tagIn;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  // the line is empty once no slot holds a read
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) empty &= ~stage[i].live;
  end
  assign tagOut = stage[DEPTH-1];
endmodule

// File: rtl/conv_scheduler.sv
// conv_scheduler: raster read sequencer with credit flow control and output tagging
module conv_scheduler import conv_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int F = F_DEF,
  parameter int DIM_WIDTH = 7,
  parameter int ADDR_WIDTH = 14,
  parameter int CONV_LAT = CONV_LAT_DEF,
  parameter int CREDITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  conv_valid,
  input  logic                  credit_ret,
  output logic                  out_valid,
  output logic [DIM_WIDTH-1:0]  out_row,
  output logic [DIM_WIDTH-1:0]  out_col,
  output logic                  busy,
  output logic                  done,
  output logic                  credit_err
);
  localparam int CW = $clog2(CREDITS + 1);
  if (DIM_WIDTH > TAG_DIM || DATA_WIDTH < 1) begin : gBadParams
    $error("conv_scheduler: DIM_WIDTH wider than tag fields or bad DATA_WIDTH");
  end
  state_t state, nextState;
  logic [DIM_WIDTH-1:0] r, c, w, h;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] credits;
  logic winComplete, lastPix, take, overflow, drainEmpty;
  tag_t tagIn, tagOut;
  assign winComplete = r >= DIM_WIDTH'(F - 1) && c >= DIM_WIDTH'(F - 1);
  assign lastPix = r == h - 1'b1 && c == w - 1'b1;
  assign take = mem_rd_en && winComplete;
  assign overflow = credit_ret && credits == CW'(CREDITS);
  // next state and read strobe; a complete window may only issue with a credit in hand
  always_comb begin
    nextState = state;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: if (start) nextState = (cfg_width < DIM_WIDTH'(F) || cfg_height < DIM_WIDTH'(F)) ? DONE : FEED;
      FEED: begin
        mem_rd_en = !winComplete || credits != '0;
        if (mem_rd_en && lastPix) nextState = DRAIN;
      end
      DRAIN: if (drainEmpty) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  // state, latched geometry and raster position; position moves only on an issued read
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      w <= '0;
      h <= '0;
      addr <= '0;
      conv_valid <= 1'b0;
    end else begin
      state <= nextState;
      conv_valid <= mem_rd_en;
      if (state == IDLE && start) begin
        w <= cfg_width;
        h <= cfg_height;
        r <= '0;
        c <= '0;
        addr <= '0;
      end else if (mem_rd_en) begin
        addr <= addr + 1'b1;
        c <= c == w - 1'b1 ? '0 : c + 1'b1;
        r <= c == w - 1'b1 ? r + 1'b1 : r;
      end
    end
  end
  // credits track free downstream FIFO slots; a pop with nothing outstanding is flagged and dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      credits <= credits - CW'(take) + CW'(credit_ret && !overflow);
      credit_err <= credit_err | overflow;
    end
  end
  assign tagIn = '{live: mem_rd_en, win: winComplete,
                   row: TAG_DIM'(r - DIM_WIDTH'(F - 1)), col: TAG_DIM'(c - DIM_WIDTH'(F - 1))};
  conv_tag_delay #(.DEPTH(1 + CONV_LAT)) uTag (
    .clk(clk),
    .rst(rst),
    .tagIn(tagIn),
    .tagOut(tagOut),
    .empty(drainEmpty)
  );
  assign mem_rd_addr = addr;
  assign out_valid = tagOut.live && tagOut.win;
  assign out_row = DIM_WIDTH'(tagOut.row);
  assign out_col = DIM_WIDTH'(tagOut.col);
  assign busy = state == FEED || state == DRAIN;
  assign done = state == DONE;
endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: directed checks of read order, credits, tagging, reset and short images
module tb_conv_scheduler;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, credit_ret = 1'b0;
  logic [6:0] cfg_width = '0, cfg_height = '0;
  logic mem_rd_en, conv_valid, out_valid, busy, done, credit_err;
  logic [13:0] mem_rd_addr;
  logic [6:0] out_row, out_col;
  int cyc = 0, sCyc = 0, busySeen = 0, nTotal = 0, nBad = 0;
  int rdAddr[$], rdCyc[$], cvCyc[$], ovRow[$], ovCol[$], ovCyc[$], doneCyc[$];
  int expRow[6] = '{0, 0, 0, 1, 1, 1};
  int expCol[6] = '{0, 1, 2, 0, 1, 2};

  conv_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .conv_valid(conv_valid),
    .credit_ret(credit_ret), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .credit_err(credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) begin rdAddr.push_back(int'(mem_rd_addr)); rdCyc.push_back(cyc); end
    if (conv_valid) cvCyc.push_back(cyc);
    if (out_valid) begin ovRow.push_back(int'(out_row)); ovCol.push_back(int'(out_col)); ovCyc.push_back(cyc); end
    if (done) doneCyc.push_back(cyc);
    if (busy) busySeen++;
  end

  task automatic checkVal(input string tag, input int got, input int exp);
    nTotal++;
    if (got != exp) begin
      nBad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    rdAddr.delete(); rdCyc.delete(); cvCyc.delete();
    ovRow.delete(); ovCol.delete(); ovCyc.delete(); doneCyc.delete();
    busySeen = 0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic pulseStart(input int wv, input int hv);
    cfg_width = 7'(wv); cfg_height = 7'(hv);
    start = 1'b1; sCyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic runMap(input int wv, input int hv, input bit ret, input bit poke, input int budget);
    credit_ret = ret;
    pulseStart(wv, hv);
    for (int i = 0; i < budget && doneCyc.size() == 0; i++) begin
      if (poke && (i == 5 || i == 24)) begin start = 1'b1; cfg_width = 7'd3; cfg_height = 7'd3; end
      @(posedge clk); #1 start = 1'b0;
    end
    credit_ret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitRead(input int a);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = mem_rd_en && int'(mem_rd_addr) == a;
    end
    checkVal("reachAddr", int'(hit), 1);
  endtask

  function automatic int windowReads(input int wv);
    int n = 0;
    foreach (rdAddr[i]) if (rdAddr[i] / wv >= 2 && rdAddr[i] % wv >= 2) n++;
    return n;
  endfunction

  task automatic checkFullMap(input string pfx);
    checkVal({pfx, "_reads"}, rdAddr.size(), 20);
    foreach (rdAddr[i]) checkVal({pfx, "_addr"}, rdAddr[i], i);
    if (rdAddr.size() == 20) begin
      checkVal({pfx, "_firstRdCyc"}, rdCyc[0], sCyc + 1);
      checkVal({pfx, "_consecutive"}, rdCyc[19] - rdCyc[0], 19);
    end
    checkVal({pfx, "_convValidCnt"}, cvCyc.size(), 20);
    if (cvCyc.size() > 0 && rdCyc.size() > 0) checkVal({pfx, "_convValidLag"}, cvCyc[0] - rdCyc[0], 1);
    checkVal({pfx, "_outCount"}, ovRow.size(), 6);
    foreach (ovRow[i]) if (i < 6) begin
      checkVal({pfx, "_outRow"}, ovRow[i], expRow[i]);
      checkVal({pfx, "_outCol"}, ovCol[i], expCol[i]);
    end
    if (ovCyc.size() > 0 && rdCyc.size() > 12) checkVal({pfx, "_firstOutLag"}, ovCyc[0] - rdCyc[12], 8);
    checkVal({pfx, "_doneCount"}, doneCyc.size(), 1);
    if (doneCyc.size() > 0 && ovCyc.size() == 6) checkVal({pfx, "_doneAfterDrain"}, doneCyc[0] - ovCyc[5], 2);
  endtask

  initial begin
    doReset();
    @(negedge clk);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_done", int'(done), 0);
    checkVal("rst_rdEn", int'(mem_rd_en), 0);
    checkVal("rst_outValid", int'(out_valid), 0);
    checkVal("rst_creditErr", int'(credit_err), 0);
    checkVal("rst_credits", int'(dut.credits), 8);

    // 5x4 image, credits returned every cycle
    clearLog();
    runMap(5, 4, 1'b1, 1'b0, 200);
    checkFullMap("map5x4");

    // 8x8 image, no credit returns: stalls after 8 window reads
    doReset(); clearLog();
    credit_ret = 1'b0;
    pulseStart(8, 8);
    repeat (60) @(posedge clk);
    #1;
    checkVal("stall_reads", rdAddr.size(), 28);
    checkVal("stall_windows", windowReads(8), 8);
    checkVal("stall_busy", int'(busy), 1);
    credit_ret = 1'b1;
    @(posedge clk); #1 credit_ret = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkVal("release_reads", rdAddr.size(), 29);
    if (rdAddr.size() > 28) checkVal("release_addr", rdAddr[28], 28);
    checkVal("release_windows", windowReads(8), 9);

    // 2x5 image is too narrow: straight to done
    doReset(); clearLog();
    runMap(2, 5, 1'b0, 1'b0, 10);
    checkVal("narrow_doneCount", doneCyc.size(), 1);
    if (doneCyc.size() > 0) checkVal("narrow_doneCyc", doneCyc[0], sCyc + 1);
    checkVal("narrow_reads", rdAddr.size(), 0);
    checkVal("narrow_busy", busySeen, 0);

    // start pulses during FEED and DRAIN must be ignored
    doReset(); clearLog();
    runMap(5, 4, 1'b1, 1'b1, 200);
    checkFullMap("ignStart");

    // reset in the middle of FEED
    doReset(); clearLog();
    pulseStart(5, 4);
    waitRead(7);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkVal("abort_busy", int'(busy), 0);
    checkVal("abort_rdEn", int'(mem_rd_en), 0);
    checkVal("abort_convValid", int'(conv_valid), 0);
    checkVal("abort_outValid", int'(out_valid), 0);
    checkVal("abort_done", int'(done), 0);
    checkVal("abort_creditErr", int'(credit_err), 0);
    checkVal("abort_credits", int'(dut.credits), 8);
    clearLog();
    repeat (15) @(posedge clk);
    #1;
    checkVal("abort_noDone", doneCyc.size(), 0);
    checkVal("abort_noOut", ovCyc.size(), 0);
    runMap(5, 4, 1'b1, 1'b0, 200);
    checkFullMap("restart");

    // coincident return and window read at credits=3
    doReset(); clearLog();
    pulseStart(8, 8);
    waitRead(23);
    checkVal("coin_before", int'(dut.credits), 3);
    credit_ret = 1'b1;
    @(posedge clk); #1 credit_ret = 1'b0;
    @(negedge clk);
    checkVal("coin_after", int'(dut.credits), 3);

    // return with all credits home is flagged and ignored
    doReset();
    @(negedge clk);
    checkVal("ovf_errBefore", int'(credit_err), 0);
    credit_ret = 1'b1;
    @(posedge clk); #1 credit_ret = 1'b0;
    @(negedge clk);
    checkVal("ovf_err", int'(credit_err), 1);
    checkVal("ovf_credits", int'(dut.credits), 8);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule
